// File: rtl/vdc_pkg.sv
// Shared VDC types: VRAM geometry, requester ids and read-return tags.
package vdc_pkg;

  localparam int unsigned VRAM_ADDR_W = 16;
  localparam int unsigned VRAM_DATA_W = 16;

  typedef enum logic [1:0] {REQ_BG, REQ_SPR, REQ_CPU, REQ_DMA} req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } vram_tag_t;

endpackage

// File: rtl/vdc_vram_arbiter_if.sv
// Requester handshakes plus the single VRAM port, shared by the arbiter and its environment.
interface vdc_vram_arbiter_if
  import vdc_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
);

  logic              display_active;
  logic              bg_req,    spr_req;
  logic [ADDR_W-1:0] bg_addr,   spr_addr;
  logic              cpu_req,   dma_req;
  logic              cpu_we,    dma_we;
  logic [ADDR_W-1:0] cpu_addr,  dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              bg_gnt,    spr_gnt,    cpu_gnt,    dma_gnt;
  logic              bg_rvalid, spr_rvalid, cpu_rvalid, dma_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] MA;
  logic [DATA_W-1:0] MD_in;
  logic              vram_we;
  logic [DATA_W-1:0] MD_out;

  modport master (
    output display_active, bg_req, spr_req, bg_addr, spr_addr,
           cpu_req, dma_req, cpu_we, dma_we, cpu_addr, dma_addr, cpu_wdata, dma_wdata,
           MD_out,
    input  bg_gnt, spr_gnt, cpu_gnt, dma_gnt,
           bg_rvalid, spr_rvalid, cpu_rvalid, dma_rvalid, rdata, MA, MD_in, vram_we
  );

  modport slave (
    input  display_active, bg_req, spr_req, bg_addr, spr_addr,
           cpu_req, dma_req, cpu_we, dma_we, cpu_addr, dma_addr, cpu_wdata, dma_wdata,
           MD_out,
    output bg_gnt, spr_gnt, cpu_gnt, dma_gnt,
           bg_rvalid, spr_rvalid, cpu_rvalid, dma_rvalid, rdata, MA, MD_in, vram_we
  );

endinterface

// File: rtl/vdc_starve_counter.sv
// Saturating 4-bit wait counter; promote_o rises once a requester has waited MaxWait cycles.
module vdc_starve_counter #(
  parameter int unsigned MaxWait = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req_i,
  input  logic gnt_i,
  output logic promote_o
);

  localparam logic [3:0] MaxWaitW = 4'(MaxWait);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!req_i || gnt_i) begin
      count_d = 4'd0;
    end else if (count_q != 4'hF) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign promote_o = (count_q >= MaxWaitW);

endmodule

// File: rtl/vdc_vram_arbiter.sv
// Single-port VRAM arbiter: one access per cycle, read data returned two cycles later with a tag.
module vdc_vram_arbiter
  import vdc_pkg::*;
#(
  parameter int unsigned ADDR_W       = VRAM_ADDR_W,
  parameter int unsigned DATA_W       = VRAM_DATA_W,
  parameter int unsigned CPU_MAX_WAIT = 8
) (
  input logic               clock,
  input logic               reset_n,
  vdc_vram_arbiter_if.slave bus
);

  logic              cpu_promote;
  logic              win_valid;
  req_id_t           win_id;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] ma_q, ma_d;
  logic [DATA_W-1:0] md_in_q, md_in_d;
  logic              vram_we_q, vram_we_d;
  vram_tag_t [1:0]   tag_q, tag_d;

  vdc_starve_counter #(
    .MaxWait(CPU_MAX_WAIT)
  ) u_cpu_starve (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_i    (bus.cpu_req),
    .gnt_i    (bus.cpu_gnt),
    .promote_o(cpu_promote)
  );

  // Display favours the fetch engines; blanking hands the port to the CPU and DMA.
  always_comb begin
    win_valid = 1'b1;
    win_id    = REQ_BG;
    if (!reset_n) begin
      win_valid = 1'b0;
    end else if (bus.display_active) begin
      if (bus.bg_req)                       win_id = REQ_BG;
      else if (bus.cpu_req && cpu_promote)  win_id = REQ_CPU;
      else if (bus.spr_req)                 win_id = REQ_SPR;
      else if (bus.cpu_req)                 win_id = REQ_CPU;
      else if (bus.dma_req)                 win_id = REQ_DMA;
      else                                  win_valid = 1'b0;
    end else begin
      if (bus.cpu_req)                      win_id = REQ_CPU;
      else if (bus.dma_req)                 win_id = REQ_DMA;
      else if (bus.spr_req)                 win_id = REQ_SPR;
      else if (bus.bg_req)                  win_id = REQ_BG;
      else                                  win_valid = 1'b0;
    end
  end

  assign bus.bg_gnt  = win_valid && (win_id == REQ_BG);
  assign bus.spr_gnt = win_valid && (win_id == REQ_SPR);
  assign bus.cpu_gnt = win_valid && (win_id == REQ_CPU);
  assign bus.dma_gnt = win_valid && (win_id == REQ_DMA);

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    case (win_id)
      REQ_BG:  sel_addr = bus.bg_addr;
      REQ_SPR: sel_addr = bus.spr_addr;
      REQ_CPU: begin
        sel_addr  = bus.cpu_addr;
        sel_we    = bus.cpu_we;
        sel_wdata = bus.cpu_wdata;
      end
      REQ_DMA: begin
        sel_addr  = bus.dma_addr;
        sel_we    = bus.dma_we;
        sel_wdata = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    ma_d      = ma_q;
    md_in_d   = md_in_q;
    vram_we_d = 1'b0;
    if (win_valid) begin
      ma_d      = sel_addr;
      vram_we_d = sel_we;
      md_in_d   = sel_we ? sel_wdata : '0;
    end
    tag_d[0] = '{valid: win_valid && !sel_we, id: win_id};
    tag_d[1] = tag_q[0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ma_q      <= '0;
      md_in_q   <= '0;
      vram_we_q <= 1'b0;
      tag_q     <= '0;
    end else begin
      ma_q      <= ma_d;
      md_in_q   <= md_in_d;
      vram_we_q <= vram_we_d;
      tag_q     <= tag_d;
    end
  end

  assign bus.MA      = ma_q;
  assign bus.MD_in   = md_in_q;
  assign bus.vram_we = vram_we_q;

  // Stage 1 lines up with the BRAM's registered output.
  assign bus.bg_rvalid  = tag_q[1].valid && (tag_q[1].id == REQ_BG);
  assign bus.spr_rvalid = tag_q[1].valid && (tag_q[1].id == REQ_SPR);
  assign bus.cpu_rvalid = tag_q[1].valid && (tag_q[1].id == REQ_CPU);
  assign bus.dma_rvalid = tag_q[1].valid && (tag_q[1].id == REQ_DMA);
  assign bus.rdata      = bus.MD_out;

endmodule

// File: tb/tb_vdc_vram_arbiter.sv
// Bench for vdc_vram_arbiter: VRAM model, per-cycle reference model and directed scenarios.
module tb_vdc_vram_arbiter;
  import vdc_pkg::*;

  localparam int unsigned MaxWait = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 clock = ~clock;

  vdc_vram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  vdc_vram_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .CPU_MAX_WAIT(MaxWait)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic logic [15:0] preload(logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'hC3C3);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One-cycle-latency BRAM: read-before-write on the same edge.
  logic [15:0] vram [int];
  initial begin
    bus.MD_out = '0;
    forever begin
      @(posedge clock);
      bus.MD_out = vram.exists(int'(bus.MA)) ? vram[int'(bus.MA)] : preload(bus.MA);
      if (bus.vram_we) vram[int'(bus.MA)] = bus.MD_in;
    end
  end

  // Reference model: the winner is the first requesting entry of the mode's priority list;
  // read data is whatever program order says the memory holds when the read is accepted.
  function automatic logic req_of(req_id_t id);
    case (id)
      REQ_BG:  return bus.bg_req;
      REQ_SPR: return bus.spr_req;
      REQ_CPU: return bus.cpu_req;
      default: return bus.dma_req;
    endcase
  endfunction

  logic [15:0] mdl_mem [int];
  logic [15:0] exp_ma, exp_md;
  logic        exp_we;
  logic        pv    [2];
  req_id_t     pid   [2];
  logic [15:0] pdata [2];
  int          wait_cnt;

  initial begin
    req_id_t     order [4];
    req_id_t     win;
    logic        found;
    logic [15:0] a, wd;
    logic        we;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        check("rst_gnt", {bus.bg_gnt, bus.spr_gnt, bus.cpu_gnt, bus.dma_gnt}, 0);
        check("rst_rvalid", {bus.bg_rvalid, bus.spr_rvalid, bus.cpu_rvalid, bus.dma_rvalid}, 0);
        check("rst_ma", bus.MA, 0);
        check("rst_md_in", bus.MD_in, 0);
        check("rst_we", bus.vram_we, 0);
        exp_ma = '0; exp_md = '0; exp_we = 1'b0; wait_cnt = 0;
        pv[0] = 1'b0; pv[1] = 1'b0;
      end else begin
        if (!bus.display_active)            order = '{REQ_CPU, REQ_DMA, REQ_SPR, REQ_BG};
        else if (wait_cnt >= int'(MaxWait)) order = '{REQ_BG, REQ_CPU, REQ_SPR, REQ_DMA};
        else                                order = '{REQ_BG, REQ_SPR, REQ_CPU, REQ_DMA};
        found = 1'b0;
        win   = REQ_BG;
        for (int i = 0; i < 4; i++) begin
          if (!found && req_of(order[i])) begin
            found = 1'b1;
            win   = order[i];
          end
        end
        check("gnt", {bus.bg_gnt, bus.spr_gnt, bus.cpu_gnt, bus.dma_gnt},
              found ? (4'b1000 >> int'(win)) : 4'b0000);
        check("ma", bus.MA, exp_ma);
        check("md_in", bus.MD_in, exp_md);
        check("vram_we", bus.vram_we, exp_we);
        check("rvalid", {bus.bg_rvalid, bus.spr_rvalid, bus.cpu_rvalid, bus.dma_rvalid},
              pv[1] ? (4'b1000 >> int'(pid[1])) : 4'b0000);
        if (pv[1]) check("rdata", bus.rdata, pdata[1]);

        pv[1] = pv[0]; pid[1] = pid[0]; pdata[1] = pdata[0];
        pv[0] = 1'b0;
        exp_we = 1'b0;
        if (found) begin
          case (win)
            REQ_BG:  begin a = bus.bg_addr;  we = 1'b0;       wd = '0;            end
            REQ_SPR: begin a = bus.spr_addr; we = 1'b0;       wd = '0;            end
            REQ_CPU: begin a = bus.cpu_addr; we = bus.cpu_we; wd = bus.cpu_wdata; end
            default: begin a = bus.dma_addr; we = bus.dma_we; wd = bus.dma_wdata; end
          endcase
          exp_ma = a;
          exp_we = we;
          exp_md = we ? wd : 16'h0000;
          if (we) begin
            mdl_mem[int'(a)] = wd;
          end else begin
            pv[0]    = 1'b1;
            pid[0]   = win;
            pdata[0] = mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : preload(a);
          end
        end
        if (bus.cpu_req && !(found && win == REQ_CPU)) wait_cnt = (wait_cnt < 15) ? wait_cnt + 1 : 15;
        else                                           wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  initial begin
    int got;
    int n_cpu, n_dma, n_any;
    bus.display_active = 1'b1;
    bus.bg_req  = 1'b0; bus.spr_req = 1'b0; bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    bus.bg_addr = '0;   bus.spr_addr = '0;  bus.cpu_addr = '0;  bus.dma_addr = '0;
    bus.cpu_we  = 1'b0; bus.dma_we  = 1'b0; bus.cpu_wdata = '0; bus.dma_wdata = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Lone CPU read of a preloaded word.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
    sample(); check("t1_gnt", bus.cpu_gnt, 1);
    step(); bus.cpu_req = 1'b0;
    sample(); check("t1_ma", bus.MA, 16'h1234); check("t1_rvalid_early", bus.cpu_rvalid, 0);
    step();
    sample(); check("t1_rvalid", bus.cpu_rvalid, 1); check("t1_rdata", bus.rdata, 16'hBEEF);
    step();
    sample(); check("t1_rvalid_once", bus.cpu_rvalid, 0);

    // Display priority: bg first, then spr, cpu starves meanwhile.
    step();
    bus.display_active = 1'b1;
    bus.bg_req  = 1'b1; bus.bg_addr  = 16'h2000;
    bus.spr_req = 1'b1; bus.spr_addr = 16'h3000;
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0400;
    for (int i = 0; i < 4; i++) begin
      sample(); check("t2_bg", bus.bg_gnt, 1); check("t2_cpu_blocked", bus.cpu_gnt, 0);
      step(); bus.bg_addr = bus.bg_addr + 16'd1;
    end
    bus.bg_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample(); check("t2_spr", bus.spr_gnt, 1); check("t2_cpu_blocked", bus.cpu_gnt, 0);
      step(); bus.spr_addr = bus.spr_addr + 16'd1;
    end
    bus.spr_req = 1'b0;
    sample(); check("t2_cpu_last", bus.cpu_gnt, 1);
    step(); bus.cpu_req = 1'b0;

    // Promotion: cpu wins on its ninth waiting cycle against a continuous spr stream.
    step();
    bus.spr_req = 1'b1; bus.spr_addr = 16'h3100;
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0500;
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      sample();
      if (bus.cpu_gnt) got = i;
      else check("t3_spr_before", bus.spr_gnt, 1);
      step();
      if (got != 0) break;
    end
    bus.cpu_req = 1'b0;
    check("t3_cpu_wait_cycle", got, 9);
    sample(); check("t3_spr_resume", bus.spr_gnt, 1);
    step(); bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0501;
    sample(); check("t3_counter_cleared", bus.cpu_gnt, 0);
    step(); bus.spr_req = 1'b0;
    sample(); check("t3_cpu_after", bus.cpu_gnt, 1);
    step(); bus.cpu_req = 1'b0;

    // Blanking: cpu write then dma read of the same word.
    bus.display_active = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'hA5A5;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0010;
    sample(); check("t4_cpu_first", {bus.cpu_gnt, bus.dma_gnt}, 2'b10);
    step(); bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    sample(); check("t4_dma_next", bus.dma_gnt, 1); check("t4_we", bus.vram_we, 1);
    check("t4_md_in", bus.MD_in, 16'hA5A5);
    step(); bus.dma_req = 1'b0;
    sample(); check("t4_write_no_rvalid", bus.cpu_rvalid, 0);
    step();
    sample(); check("t4_dma_rvalid", bus.dma_rvalid, 1); check("t4_dma_rdata", bus.rdata, 16'hA5A5);

    // Alternating cpu/dma reads back to back.
    step();
    n_cpu = 0; n_dma = 0;
    for (int k = 0; k < 10; k++) begin
      bus.cpu_req = (k < 8) && (k % 2 == 0); bus.cpu_addr = 16'h0100 + 16'(k);
      bus.dma_req = (k < 8) && (k % 2 == 1); bus.dma_addr = 16'h0100 + 16'(k);
      sample();
      if (k < 8) check("t5_gnt", (k % 2 == 0) ? bus.cpu_gnt : bus.dma_gnt, 1);
      n_cpu += int'(bus.cpu_rvalid);
      n_dma += int'(bus.dma_rvalid);
      step();
    end
    check("t5_cpu_rvalids", n_cpu, 4);
    check("t5_dma_rvalids", n_dma, 4);

    // Reset in the cycle after a read is accepted flushes it.
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0777;
    sample(); check("t6_gnt", bus.cpu_gnt, 1);
    step(); bus.cpu_req = 1'b0; reset_n = 1'b0;
    sample(); check("t6_ma", bus.MA, 0); check("t6_we", bus.vram_we, 0);
    step(); reset_n = 1'b1;
    n_any = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      n_any += int'(bus.bg_rvalid) + int'(bus.spr_rvalid) + int'(bus.cpu_rvalid)
             + int'(bus.dma_rvalid);
      step();
    end
    check("t6_no_rvalid", n_any, 0);
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h1234;
    sample(); check("t6_post_gnt", bus.cpu_gnt, 1);
    step(); bus.cpu_req = 1'b0;
    sample(); check("t6_post_ma", bus.MA, 16'h1234);
    step();
    sample(); check("t6_post_rdata", {bus.cpu_rvalid, bus.rdata}, {1'b1, 16'hBEEF});
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
